// File: rtl/cycle_ctrl_if.sv
// Machine-cycle sequencer bus: phase/control inputs and
// state/status outputs of the 5401 cycle controller.
interface cycle_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             CLK1;
  logic             RDY;
  logic             LONG;
  logic             HALT_REQ;
  logic             STEP;
  logic [2:0]       STATE;
  logic             SYNC;
  logic             HALT_ACK;
  logic [3:0]       WAITS;
  logic [CNT_W-1:0] RETIRED;

  modport master (
    output CLK1,
    output RDY,
    output LONG,
    output HALT_REQ,
    output STEP,
    input  STATE,
    input  SYNC,
    input  HALT_ACK,
    input  WAITS,
    input  RETIRED
  );

  modport slave (
    input  CLK1,
    input  RDY,
    input  LONG,
    input  HALT_REQ,
    input  STEP,
    output STATE,
    output SYNC,
    output HALT_ACK,
    output WAITS,
    output RETIRED
  );
endinterface

// File: rtl/cycle_ctrl.sv
// 5401 machine-cycle sequencer: FETCH/DECODE/EXEC/WB stepping
// on CLK1 rising edges, with wait states, halt and single-step.
module cycle_ctrl #(
  parameter int CNT_W = 8
) (
  input logic        CLK,
  input logic        RST,
  cycle_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    RESET   = 3'b000,
    FETCH   = 3'b001,
    DECODE  = 3'b010,
    EXEC1   = 3'b011,
    EXEC2   = 3'b100,
    WB      = 3'b101,
    HALTED  = 3'b110,
    ILLEGAL = 3'b111
  } state_t;

  state_t           state;
  state_t           stateNxt;
  logic             clk1Q;
  logic             stepQ;
  logic             longQ;
  logic             stepPend;
  logic             sync;
  logic             haltAck;
  logic [3:0]       waits;
  logic [CNT_W-1:0] retired;

  logic adv;
  logic stepEdge;
  logic enterFetch;

  // CLK1 is only a qualifier; one strobe per rising edge
  assign adv      = bus.CLK1 & ~clk1Q;
  assign stepEdge = bus.STEP & ~stepQ;

  always_comb begin
    stateNxt = state;
    if (adv) begin
      unique case (state)
        RESET:   stateNxt = FETCH;
        FETCH:   stateNxt = bus.RDY ? DECODE : FETCH;
        DECODE:  stateNxt = EXEC1;
        EXEC1:   stateNxt = longQ ? EXEC2 : WB;
        EXEC2:   stateNxt = WB;
        WB:      stateNxt = bus.HALT_REQ ? HALTED : FETCH;
        HALTED: begin
          if (!bus.HALT_REQ || stepPend || stepEdge)
            stateNxt = FETCH;
        end
        ILLEGAL: stateNxt = FETCH;
      endcase
    end
  end

  assign enterFetch = adv & (stateNxt == FETCH) & (state != FETCH);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= RESET;
      clk1Q   <= 1'b0;
      stepQ   <= 1'b0;
      sync    <= 1'b0;
      haltAck <= 1'b0;
    end else begin
      state   <= stateNxt;
      clk1Q   <= bus.CLK1;
      stepQ   <= bus.STEP;
      sync    <= enterFetch;
      haltAck <= (stateNxt == HALTED);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      longQ <= 1'b0;
    end else if (adv && state == DECODE) begin
      longQ <= bus.LONG;
    end
  end

  // WAITS survives DECODE..WB so debug can read the last fetch
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      waits <= 4'd0;
    end else if (enterFetch) begin
      waits <= 4'd0;
    end else if (adv && state == FETCH && !bus.RDY
                 && waits != 4'd15) begin
      waits <= waits + 4'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      retired <= '0;
    end else if (adv && state == WB) begin
      retired <= retired + CNT_W'(1);
    end
  end

  // A step coinciding with the releasing adv is consumed directly
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      stepPend <= 1'b0;
    end else if (adv && state == HALTED
                 && stateNxt == FETCH) begin
      stepPend <= 1'b0;
    end else if (state == HALTED && stepEdge) begin
      stepPend <= 1'b1;
    end
  end

  assign bus.STATE    = state;
  assign bus.SYNC     = sync;
  assign bus.HALT_ACK = haltAck;
  assign bus.WAITS    = waits;
  assign bus.RETIRED  = retired;

endmodule

// File: tb/tb_cycle_ctrl.sv
// Scoreboard bench for cycle_ctrl: a reference model pushes the
// expected post-advance outputs, checked after each adv edge.
module tb_cycle_ctrl;

  localparam logic [2:0] S_RESET  = 3'b000;
  localparam logic [2:0] S_FETCH  = 3'b001;
  localparam logic [2:0] S_DECODE = 3'b010;
  localparam logic [2:0] S_EXEC1  = 3'b011;
  localparam logic [2:0] S_EXEC2  = 3'b100;
  localparam logic [2:0] S_WB     = 3'b101;
  localparam logic [2:0] S_HALTED = 3'b110;

  typedef struct packed {
    logic [2:0] st;
    logic [3:0] w;
    logic [7:0] r;
    logic       ack;
    logic       sync;
  } exp_t;

  logic clk;
  logic rstN;
  int   nChecks;
  int   nFails;

  exp_t sb[$];

  logic [2:0] mState;
  logic [3:0] mWaits;
  logic [7:0] mRet;
  logic       mLong;
  logic       mPend;

  cycle_ctrl_if #(.CNT_W(8)) bus ();

  cycle_ctrl #(.CNT_W(8)) dut (
    .CLK (clk),
    .RST (rstN),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mState = S_RESET;
    mWaits = 4'd0;
    mRet   = 8'd0;
    mLong  = 1'b0;
    mPend  = 1'b0;
  endtask

  task automatic popCheck();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sbUnderflow", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("state",   bus.STATE,    e.st);
      chk("waits",   bus.WAITS,    e.w);
      chk("retired", bus.RETIRED,  e.r);
      chk("haltAck", bus.HALT_ACK, e.ack);
      chk("sync",    bus.SYNC,     e.sync);
    end
  endtask

  task automatic advance(input int width = 1,
                         input bit stepToo = 1'b0);
    exp_t       e;
    logic [2:0] ns;
    @(negedge clk);
    bus.CLK1 = 1'b1;
    if (stepToo) bus.STEP = 1'b1;
    ns     = mState;
    e.sync = 1'b0;
    case (mState)
      S_RESET:  ns = S_FETCH;
      S_FETCH: begin
        if (bus.RDY) ns = S_DECODE;
        else if (mWaits != 4'd15) mWaits = mWaits + 4'd1;
      end
      S_DECODE: begin
        mLong = bus.LONG;
        ns    = S_EXEC1;
      end
      S_EXEC1:  ns = mLong ? S_EXEC2 : S_WB;
      S_EXEC2:  ns = S_WB;
      S_WB: begin
        mRet = mRet + 8'd1;
        ns   = bus.HALT_REQ ? S_HALTED : S_FETCH;
      end
      S_HALTED: begin
        if (!bus.HALT_REQ || mPend || stepToo) begin
          ns    = S_FETCH;
          mPend = 1'b0;
        end
      end
      default:  ns = S_FETCH;
    endcase
    if (ns == S_FETCH && mState != S_FETCH) begin
      mWaits = 4'd0;
      e.sync = 1'b1;
    end
    mState = ns;
    e.st   = mState;
    e.w    = mWaits;
    e.r    = mRet;
    e.ack  = (mState == S_HALTED);
    sb.push_back(e);
    @(posedge clk);
    #1;
    popCheck();
    for (int i = 1; i < width; i++) begin
      @(posedge clk);
      #1;
      chk("holdState", bus.STATE, mState);
      chk("holdSync", bus.SYNC, 1'b0);
    end
    @(negedge clk);
    bus.CLK1 = 1'b0;
    bus.STEP = 1'b0;
    repeat (2) @(negedge clk);
    chk("syncLow", bus.SYNC, 1'b0);
  endtask

  task automatic pulseStep();
    @(negedge clk);
    bus.STEP = 1'b1;
    if (mState == S_HALTED) mPend = 1'b1;
    @(negedge clk);
    bus.STEP = 1'b0;
  endtask

  task automatic checkZero(input string tag);
    chk({tag, "State"},   bus.STATE,    3'd0);
    chk({tag, "Sync"},    bus.SYNC,     1'b0);
    chk({tag, "Ack"},     bus.HALT_ACK, 1'b0);
    chk({tag, "Waits"},   bus.WAITS,    4'd0);
    chk({tag, "Retired"}, bus.RETIRED,  8'd0);
  endtask

  initial begin
    logic [7:0] startRet;
    logic [7:0] prevRet;
    int         done;
    nChecks      = 0;
    nFails       = 0;
    bus.CLK1     = 1'b0;
    bus.RDY      = 1'b1;
    bus.LONG     = 1'b0;
    bus.HALT_REQ = 1'b0;
    bus.STEP     = 1'b0;
    rstN         = 1'b0;
    modelReset();
    repeat (3) @(negedge clk);
    checkZero("rst");
    rstN = 1'b1;
    repeat (2) @(negedge clk);

    // free run
    for (int i = 0; i < 13; i++) advance();
    chk("ret13", bus.RETIRED, 8'd3);

    // wait states
    bus.RDY = 1'b0;
    for (int i = 0; i < 3; i++) advance();
    bus.RDY = 1'b1;
    advance();
    chk("waitsDecode", bus.WAITS, 4'd3);
    advance();
    advance();
    advance();
    chk("waitsClear", bus.WAITS, 4'd0);
    bus.RDY = 1'b0;
    for (int i = 0; i < 20; i++) advance();
    chk("waitsSat", bus.WAITS, 4'd15);
    bus.RDY = 1'b1;
    advance();

    // LONG only counts at DECODE exit
    bus.LONG = 1'b0;
    advance();
    bus.LONG = 1'b1;
    advance();
    chk("noExec2", bus.STATE, S_WB);
    advance();
    advance();
    advance();
    bus.LONG = 1'b0;
    advance();
    chk("exec2", bus.STATE, S_EXEC2);
    advance();
    advance();

    // halt raised mid-instruction
    advance();
    advance();
    bus.HALT_REQ = 1'b1;
    advance();
    advance();
    chk("haltState", bus.STATE, S_HALTED);
    chk("haltAck", bus.HALT_ACK, 1'b1);
    advance();

    // single step
    prevRet = mRet;
    pulseStep();
    for (int i = 0; i < 5; i++) advance();
    chk("stepRet", bus.RETIRED, prevRet + 8'd1);
    chk("stepHalt", bus.STATE, S_HALTED);

    // step edge coinciding with adv
    advance(1, 1'b1);
    chk("stepSame", bus.STATE, S_FETCH);
    for (int i = 0; i < 4; i++) advance();

    // step outside HALTED is ignored
    advance(1, 1'b1);
    pulseStep();
    for (int i = 0; i < 4; i++) advance();
    advance();
    chk("stepIgnored", bus.STATE, S_HALTED);

    // resume
    bus.HALT_REQ = 1'b0;
    advance();
    chk("resume", bus.STATE, S_FETCH);

    // wide CLK1
    advance(5);
    advance();

    // wrap
    while (mState != S_FETCH) advance();
    startRet = mRet;
    done     = 0;
    while (done < 256) begin
      prevRet = mRet;
      advance();
      if (mRet != prevRet) done++;
    end
    chk("wrap", bus.RETIRED, startRet);

    // abort during EXEC2
    advance();
    bus.LONG = 1'b1;
    advance();
    bus.LONG = 1'b0;
    advance();
    chk("preAbort", bus.STATE, S_EXEC2);
    @(posedge clk);
    #3;
    rstN = 1'b0;
    #1;
    checkZero("abort");
    modelReset();
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    advance();
    chk("postAbort", bus.STATE, S_FETCH);

    chk("sbEmpty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFails);
    $finish;
  end

endmodule
